// File: rtl/cam_capture.sv
// cam_capture: captures one camera frame (two bytes per pixel, href-qualified
// lines, vsync-delimited frames) into a linear frame buffer through a simple
// write-strobe port. Capture is armed by i_start and always begins at the
// next clean vsync falling edge.
//
// Optional feature: define CAM_CAPTURE_OVERFLOW_EN to build the sticky
// o_overflow flag. Without it, o_overflow is a constant 0.
module cam_capture #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 640 * 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_vsync,
  input  logic                     i_href,
  input  logic [7:0]               i_data,
  output logic                     o_wr,
  output logic [$clog2(DEPTH)-1:0] o_wr_addr,
  output logic [WIDTH-1:0]         o_wr_data,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          vs_q, vs_d;
  logic          phase_q, phase_d;
  logic [7:0]    byte_q, byte_d;
  logic          end_pend_q, end_pend_d;
  logic          wr_q, wr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic vs_fall_s;
  logic vs_rise_s;
  logic capturing_s;
  logic pix_done_s;
  logic frame_end_s;
  logic arm_s;
  logic frame_start_s;
  logic room_s;

  // Pixel word: high byte arrives first; keep only the low WIDTH bits.
  function automatic logic [WIDTH-1:0] pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
    return WIDTH'({hi, lo});
  endfunction

  assign vs_fall_s     = vs_q & ~i_vsync;
  assign vs_rise_s     = ~vs_q & i_vsync;
  // The extra cycle after a vsync rise that carried a final byte is not a sampling cycle.
  assign capturing_s   = (state_q == ST_CAPTURE) & ~end_pend_q;
  assign pix_done_s    = capturing_s & i_href & phase_q;
  // A frame ends on vsync rise, deferred by one cycle when that rise also completes a pixel.
  assign frame_end_s   = (state_q == ST_CAPTURE) & (end_pend_q | (vs_rise_s & ~pix_done_s));
  assign arm_s         = (state_q == ST_IDLE) & i_start;
  assign frame_start_s = (state_q == ST_WAIT_VS) & vs_fall_s;
  assign room_s        = (cnt_q < DEPTH_CNT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; i_start is only consulted when idle or at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_WAIT_VS;
        else         state_d = ST_IDLE;
      end
      ST_WAIT_VS: begin
        if (vs_fall_s) state_d = ST_CAPTURE;
        else           state_d = ST_WAIT_VS;
      end
      ST_CAPTURE: begin
        if (frame_end_s) begin
          if (i_start) state_d = ST_WAIT_VS;
          else         state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: byte pairing, write strobe, address/count.
  always_comb begin
    vs_d         = i_vsync;
    phase_d      = 1'b0;
    byte_d       = byte_q;
    end_pend_d   = 1'b0;
    wr_d         = 1'b0;
    wr_data_d    = wr_data_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = frame_end_s;

    // Byte phase toggles per href byte; drops back to 0 between lines and at frame end.
    if (capturing_s && i_href && !vs_rise_s) begin
      phase_d = ~phase_q;
      if (!phase_q) byte_d = i_data;
      else          byte_d = byte_q;
    end else begin
      phase_d = 1'b0;
    end

    if (capturing_s && vs_rise_s && pix_done_s) begin
      end_pend_d = 1'b1;
    end else begin
      end_pend_d = 1'b0;
    end

    // Only the first DEPTH pixels of a frame reach the buffer.
    if (pix_done_s && room_s) begin
      wr_d      = 1'b1;
      wr_data_d = pack_pixel(byte_q, i_data);
      cnt_d     = cnt_q + CW'(1);
    end else begin
      wr_d      = 1'b0;
    end

    // Address advances after each write and saturates; restarts at arm and frame start.
    if (arm_s || frame_start_s) begin
      addr_d = '0;
      cnt_d  = '0;
    end else if (wr_q && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + AW'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q         <= 1'b0;
      phase_q      <= 1'b0;
      byte_q       <= 8'h00;
      end_pend_q   <= 1'b0;
      wr_q         <= 1'b0;
      wr_data_q    <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      vs_q         <= vs_d;
      phase_q      <= phase_d;
      byte_q       <= byte_d;
      end_pend_q   <= end_pend_d;
      wr_q         <= wr_d;
      wr_data_q    <= wr_data_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_wr         = wr_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

`ifdef CAM_CAPTURE_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: set by a completed pixel beyond DEPTH, cleared at the next frame start.
  always_comb begin
    ovf_d = ovf_q;
    if (frame_start_s) begin
      ovf_d = 1'b0;
    end else if (pix_done_s && !room_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture (DEPTH=16, WIDTH=12). Stimulus pushes the
// expected frame-buffer writes; a negedge monitor pops and compares them.
module tb_cam_capture;

  localparam int WIDTH = 12;
  localparam int DEPTH = 16;
`ifdef CAM_CAPTURE_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_href = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_wr;
  logic [3:0]  o_wr_addr;
  logic [11:0] o_wr_data;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_seen = 0;
  int fd_exp  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  cam_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_vsync(i_vsync),
    .i_href(i_href), .i_data(i_data), .o_wr(o_wr), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_overflow(o_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_href = 1'b1;
    i_data = b;
    step();
  endtask

  task automatic end_line();
    i_href = 1'b0;
    i_data = 8'h00;
    step();
  endtask

  task automatic pixel(input logic [7:0] b0, input logic [7:0] b1);
    send_byte(b0);
    send_byte(b1);
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [11:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic frame_begin();
    i_vsync = 1'b1;
    step();
    step();
    i_vsync = 1'b0;
    step();
    step();
  endtask

  task automatic frame_end();
    i_href  = 1'b0;
    i_vsync = 1'b1;
    repeat (4) step();
  endtask

  task automatic drain_check(input string tag);
    repeat (3) step();
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_frame_done_count"}, fd_seen, fd_exp);
  endtask

  // Monitor: compare each presented write against the scoreboard, count frame_done pulses.
  always @(negedge clk) begin
    logic [15:0] e;
    if (o_wr) begin
      check("wr_while_busy", o_busy, 1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wr: addr %0d data 0x%0h, no write expected", o_wr_addr, o_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", o_wr_addr, e[15:12]);
        check("wr_data", o_wr_data, e[11:0]);
      end
    end
    if (o_frame_done) fd_seen++;
  end

  initial begin
    logic [7:0] kb;

    // Reset state
    repeat (2) step();
    check("rst_wr", o_wr, 0);
    check("rst_addr", o_wr_addr, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_fd", o_frame_done, 0);
    check("rst_ovf", o_overflow, 0);
    i_rst = 1'b0;
    step();

    // Armed mid-frame: that frame is skipped, the next 4x4 frame is captured.
    pixel(8'h11, 8'h22);
    i_start = 1'b1;
    pixel(8'h33, 8'h44);
    end_line();
    check("t1_busy_wait", o_busy, 1);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) pixel(8'h55, 8'h66);
      end_line();
    end
    frame_begin();
    check("t1_busy_capture", o_busy, 1);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 4; p++) begin
        expect_wr(4'(l * 4 + p), 12'h1B2);
        pixel(8'hA1, 8'hB2);
      end
      end_line();
      if (l == 0) i_start = 1'b0;
    end
    fd_exp++;
    frame_end();
    drain_check("t1");
    check("t1_idle_busy", o_busy, 0);

    // Odd-length line: the trailing byte is dropped, next line re-pairs from phase 0.
    i_start = 1'b1;
    step();
    frame_begin();
    expect_wr(4'd0, 12'h122);
    expect_wr(4'd1, 12'h324);
    expect_wr(4'd2, 12'h526);
    for (int b = 0; b < 7; b++) send_byte(8'h21 + 8'(b));
    end_line();
    expect_wr(4'd3, 12'h132);
    expect_wr(4'd4, 12'h334);
    pixel(8'h31, 8'h32);
    pixel(8'h33, 8'h34);
    end_line();
    i_start = 1'b0;
    fd_exp++;
    frame_end();
    drain_check("t2");

    // 20-pixel frame: only 16 writes, address saturates, overflow per build.
    i_start = 1'b1;
    step();
    frame_begin();
    for (int p = 0; p < 20; p++) begin
      kb = 8'(p);
      if (p > 0 && (p % 4) == 0) end_line();
      if (p < 16) expect_wr(kb[3:0], {kb[3:0], kb + 8'h80});
      pixel(kb, kb + 8'h80);
      if (p == 15) check("t3_ovf_at_16", o_overflow, 0);
      if (p == 16) check("t3_ovf_at_17", o_overflow, 32'(OVF_EXP));
    end
    end_line();
    fd_exp++;
    frame_end();
    drain_check("t3");
    check("t3_addr_sat", o_wr_addr, 15);
    check("t3_ovf_hold", o_overflow, 32'(OVF_EXP));
    check("t3_busy_rearmed", o_busy, 1);

    // Reset after pixel 5 aborts the frame; re-arm writes a full frame from 0.
    frame_begin();
    check("t4_ovf_cleared", o_overflow, 0);
    for (int k = 0; k < 5; k++) begin
      kb = 8'(k);
      expect_wr(kb[3:0], {kb[3:0], kb + 8'h30});
      pixel(kb + 8'h70, kb + 8'h30);
    end
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_href  = 1'b0;
    step();
    check("t4_rst_wr", o_wr, 0);
    check("t4_rst_addr", o_wr_addr, 0);
    check("t4_rst_data", o_wr_data, 0);
    check("t4_rst_busy", o_busy, 0);
    check("t4_rst_fd", o_frame_done, 0);
    check("t4_rst_ovf", o_overflow, 0);
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) pixel(8'hEE, 8'hDD);
    end_line();
    frame_end();
    drain_check("t4_abort");
    check("t4_idle_busy", o_busy, 0);
    i_start = 1'b1;
    step();
    frame_begin();
    for (int k = 0; k < 16; k++) begin
      kb = 8'(k);
      if (k > 0 && (k % 4) == 0) end_line();
      expect_wr(kb[3:0], {kb[3:0], kb + 8'hE0});
      pixel(kb, kb + 8'hE0);
    end
    end_line();
    i_start = 1'b0;
    fd_exp++;
    frame_end();
    drain_check("t4_rearm");

    // Two back-to-back frames; the last pixel of frame 2 lands on the vsync rise.
    i_start = 1'b1;
    step();
    frame_begin();
    for (int k = 0; k < 16; k++) begin
      kb = 8'(k);
      if (k > 0 && (k % 4) == 0) end_line();
      expect_wr(kb[3:0], {kb[3:0], kb + 8'h20});
      pixel(kb + 8'h50, kb + 8'h20);
    end
    end_line();
    fd_exp++;
    frame_end();
    check("t5_busy_between", o_busy, 1);
    frame_begin();
    for (int k = 0; k < 15; k++) begin
      kb = 8'(k);
      if (k > 0 && (k % 4) == 0) end_line();
      if (k == 4) i_start = 1'b0;
      expect_wr(kb[3:0], {kb[3:0], kb + 8'h70});
      pixel(kb + 8'hC0, kb + 8'h70);
    end
    expect_wr(4'd15, 12'hF7F);
    send_byte(8'hCF);
    i_vsync = 1'b1;
    i_data  = 8'h7F;
    step();
    i_href = 1'b0;
    fd_exp++;
    repeat (3) step();
    drain_check("t5");
    check("t5_idle_busy", o_busy, 0);
    check("t5_last_addr", o_wr_addr, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
